fifo_rd_ctrl: RTL and testbench

//  Read-side controller for the demo FIFO: waits for the FIFO to fill, then drains it to empty in one burst.

---
 rtl/fifo_demo_pkg.sv | 13 +
 rtl/fifo_rd_ctrl_if.sv | 27 ++
 rtl/fifo_pattern_chk.sv | 37 +++
 rtl/fifo_rd_ctrl.sv | 94 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_demo_pkg.sv
// Shared types and constants for the FIFO demo read-side controller.
package fifo_demo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FULL = 2'd1,
        READ      = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int EXP_INIT   = 0;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO status/read port plus the controller's result signals, bundled for fifo_rd_ctrl.
interface fifo_rd_ctrl_if
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = 16
);
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              burst_done;
    logic [ERR_W-1:0]  err_cnt;
    logic              err_flag;

    modport master (
        input  fifo_full, fifo_empty, fifo_dout,
        output fifo_rd_en, rd_data, rd_valid, burst_done, err_cnt, err_flag
    );

    modport slave (
        output fifo_full, fifo_empty, fifo_dout,
        input  fifo_rd_en, rd_data, rd_valid, burst_done, err_cnt, err_flag
    );
endinterface

// File: rtl/fifo_pattern_chk.sv
// Compares each captured word against an incrementing reference and counts mismatches.
module fifo_pattern_chk
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_flag
);

    logic [DATA_W-1:0] expected;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The reference advances one step per word, so one corrupted word costs exactly one count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            expected <= DATA_W'(EXP_INIT);
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (rd_valid) begin
            if (rd_data != expected) begin
                err_cnt  <= sat_inc(err_cnt);
                err_flag <= 1'b1;
            end
            expected <= expected + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the FIFO demo: waits for full, drains to empty, strobes each word out.
// Optional pattern checking is built in when the macro PATTERN_CHECK_EN is defined.
module fifo_rd_ctrl
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic           sys_clk,
    input  logic           rst,
    fifo_rd_ctrl_if.master bus
);

    state_t            state;
    state_t            state_nxt;
    logic              burst_done_nxt;
    logic              rd_en;
    logic [RD_LAT-1:0] vld_p;
    logic              vld_out;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              burst_done_q;
    logic [ERR_W-1:0]  err_cnt;
    logic              err_flag;

    // Combinational enable keeps the FIFO from ever being read while empty.
    assign rd_en   = (state == READ) && !bus.fifo_empty;
    assign vld_out = vld_p[RD_LAT-1];

    always_comb begin
        state_nxt      = state;
        burst_done_nxt = 1'b0;
        case (state)
            IDLE:      state_nxt = WAIT_FULL;
            WAIT_FULL: if (bus.fifo_full) state_nxt = READ;
            READ: begin
                // Empty wins over full, which also covers the illegal both-set case.
                if (bus.fifo_empty) begin
                    state_nxt      = WAIT_FULL;
                    burst_done_nxt = 1'b1;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= IDLE;
            burst_done_q <= 1'b0;
            vld_p        <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state        <= state_nxt;
            burst_done_q <= burst_done_nxt;
            // vld_p[k] marks a read issued k+1 cycles ago; the last stage lines up with fifo_dout.
            vld_p[0]     <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            rd_valid_q   <= vld_out;
            if (vld_out) begin
                rd_data_q <= bus.fifo_dout;
            end
        end
    end

`ifdef PATTERN_CHECK_EN
    fifo_pattern_chk #(
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_chk (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .rd_valid (rd_valid_q),
        .rd_data  (rd_data_q),
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
    );
`else
    assign err_cnt  = '0;
    assign err_flag = 1'b0;
`endif

    assign bus.fifo_rd_en = rd_en;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.burst_done = burst_done_q;
    assign bus.err_cnt    = err_cnt;
    assign bus.err_flag   = err_flag;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: three instances (16b/lat1, 8b/lat1 wrap, 16b/lat2) each beside a FIFO model
// and a behavioural output model; honours PATTERN_CHECK_EN for the error-counter expectations.
module tb_fifo_rd_ctrl;

    localparam int ERR_W   = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef PATTERN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        int due;
        int w;
    } ent_t;

    typedef struct {
        int     n_valid;
        int     n_rise;
        int     n_rden;
        int     n_done;
        int     lat;
        longint sum;
    } st_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    int         fill_seq[3]  = '{0, 0, 0};
    int         fill_base[3] = '{0, 0, 0};
    int         fill_bad[3]  = '{-1, -1, -1};
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input int g, input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL u%0d %s: got=%0d want=%0d (t=%0t)", g, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : h
        localparam int DW    = (g == 1) ? 8 : 16;
        localparam int RL    = (g == 2) ? 2 : 1;
        localparam int DEPTH = (g == 1) ? 256 : 512;
        localparam int MASK  = (1 << DW) - 1;

        fifo_rd_ctrl_if #(.DATA_W(DW), .ERR_W(ERR_W)) bus ();

        fifo_rd_ctrl #(.DATA_W(DW), .RD_LAT(RL), .ERR_W(ERR_W)) dut (
            .sys_clk (clk),
            .rst     (rst_v[g]),
            .bus     (bus)
        );

        ent_t sq[$];
        int   level = 0, pops = 0, base = 0, badi = -1, seen = 0, edge_n = 0;
        int   phase = 0, nxt = 0, d1 = 0, exp_data = 0, exp_err = 0;
        bit   started = 0, exp_rd_en = 0, exp_valid = 0, exp_done = 0, exp_flag = 0;
        st_t  st = '{0, 0, 0, 0, 0, 0};
        bit   prev_re = 0, prev_v = 0;
        int   cyc = 0, t_re = 0;

        // FIFO model plus the expected controller outputs, advanced once per rising edge.
        initial begin
            bit r, re, f, e;
            int w;
            bus.fifo_full  = 1'b0;
            bus.fifo_empty = 1'b1;
            bus.fifo_dout  = '0;
            forever begin
                @(posedge clk);
                r  = rst_v[g];
                re = bus.fifo_rd_en;
                f  = bus.fifo_full;
                e  = bus.fifo_empty;
                w  = 0;
                if (re) begin
                    chk(g, "no_underflow", longint'(level > 0), 1);
                    w = (pops == badi) ? 'h55 : ((base + pops) & MASK);
                    pops++;
                    if (level > 0) level--;
                end
                if (fill_seq[g] != seen) begin
                    seen  = fill_seq[g];
                    level = DEPTH;
                    pops  = 0;
                    base  = fill_base[g];
                    badi  = fill_bad[g];
                end
                if (r) begin
                    started   = 1;
                    phase     = 0;
                    sq.delete();
                    exp_valid = 0;
                    exp_data  = 0;
                    exp_done  = 0;
                    exp_err   = 0;
                    exp_flag  = 0;
                    nxt       = 0;
                end else begin
                    if (exp_valid) begin
                        if (CHK_EN && exp_data != nxt) begin
                            if (exp_err != ERR_MAX) exp_err++;
                            exp_flag = 1;
                        end
                        nxt = (nxt + 1) & MASK;
                    end
                    exp_done = (phase == 2) && e;
                    case (phase)
                        0: phase = 1;
                        1: if (f) phase = 2;
                        default: if (e) phase = 1;
                    endcase
                    exp_valid = 0;
                    if (sq.size() > 0 && sq[0].due == edge_n) begin
                        exp_valid = 1;
                        exp_data  = sq[0].w;
                        void'(sq.pop_front());
                    end
                    if (re) sq.push_back('{edge_n + RL, w});
                end
                edge_n++;
                #1;
                if (RL == 1) begin
                    if (re) bus.fifo_dout = DW'(w);
                end else begin
                    bus.fifo_dout = DW'(d1);
                    if (re) d1 = w;
                end
                bus.fifo_full  = (level == DEPTH);
                bus.fifo_empty = (level == 0);
                exp_rd_en      = (phase == 2) && (level > 0);
            end
        end

        // Compare DUT outputs with the model every cycle, and keep running statistics.
        always @(negedge clk) begin
            if (started) begin
                chk(g, "rd_en",      bus.fifo_rd_en, exp_rd_en);
                chk(g, "rd_valid",   bus.rd_valid,   exp_valid);
                chk(g, "rd_data",    bus.rd_data,    exp_data);
                chk(g, "burst_done", bus.burst_done, exp_done);
                chk(g, "err_cnt",    bus.err_cnt,    exp_err);
                chk(g, "err_flag",   bus.err_flag,   exp_flag);
                if (bus.fifo_rd_en) st.n_rden++;
                if (bus.fifo_rd_en && !prev_re) begin
                    st.n_rise++;
                    t_re = cyc;
                end
                if (bus.rd_valid) begin
                    st.n_valid++;
                    st.sum += bus.rd_data;
                end
                if (bus.rd_valid && !prev_v) st.lat = cyc - t_re;
                if (bus.burst_done) st.n_done++;
            end
            prev_re = bus.fifo_rd_en;
            prev_v  = bus.rd_valid;
            cyc++;
        end
    end

    function automatic st_t get_st(input int g);
        if (g == 0) return h[0].st;
        if (g == 1) return h[1].st;
        return h[2].st;
    endfunction

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int g, input int b, input int badw);
        fill_base[g] = b;
        fill_bad[g]  = badw;
        fill_seq[g]  = fill_seq[g] + 1;
        nstep();
    endtask

    task automatic wait_done(input int g, input int target);
        st_t s;
        int  k = 0;
        s = get_st(g);
        while (s.n_done < target && k < 3000) begin
            nstep();
            k++;
            s = get_st(g);
        end
        chk(g, "burst_done_seen", longint'(s.n_done >= target), 1);
        repeat (4) nstep();
    endtask

    initial begin
        st_t s0, s1;
        int  k;

        // Reset held with the FIFO full: nothing may move.
        nstep();
        fill(0, 0, -1);
        repeat (20) nstep();
        chk(0, "rst_rd_en",    h[0].bus.fifo_rd_en, 0);
        chk(0, "rst_rd_valid", h[0].bus.rd_valid,   0);
        chk(0, "rst_err_cnt",  h[0].bus.err_cnt,    0);
        s0 = get_st(0);
        rst_v = 3'b000;
        k = 0;
        while (!h[0].bus.fifo_rd_en && k < 10) begin
            nstep();
            k++;
        end
        chk(0, "release_to_rd_en_cycles", k, 2);

        // Fill then drain 512 words 0..511.
        wait_done(0, s0.n_done + 1);
        s1 = get_st(0);
        chk(0, "drain_n_valid", s1.n_valid - s0.n_valid, 512);
        chk(0, "drain_n_rden",  s1.n_rden - s0.n_rden,   512);
        chk(0, "drain_rd_en_runs", s1.n_rise - s0.n_rise, 1);
        chk(0, "drain_n_done",  s1.n_done - s0.n_done,   1);
        chk(0, "drain_sum",     s1.sum - s0.sum,         130816);
        chk(0, "drain_latency", s1.lat,                  2);
        chk(0, "drain_err_cnt", h[0].bus.err_cnt,        0);

        // Word 5 corrupted to 0x0055.
        s0 = get_st(0);
        fill(0, 0, 5);
        wait_done(0, s0.n_done + 1);
        s1 = get_st(0);
        chk(0, "patt_n_valid",  s1.n_valid - s0.n_valid, 512);
        chk(0, "patt_sum",      s1.sum - s0.sum,         130896);
        chk(0, "patt_err_cnt",  h[0].bus.err_cnt,        CHK_EN ? 1 : 0);
        chk(0, "patt_err_flag", h[0].bus.err_flag,       CHK_EN ? 1 : 0);

        // Reset at word 100 of a 512-word burst.
        fill(0, 0, -1);
        k = 0;
        while (h[0].pops < 100 && k < 2000) begin
            nstep();
            k++;
        end
        chk(0, "reached_word_100", h[0].pops, 100);
        rst_v[0] = 1'b1;
        s0 = get_st(0);
        nstep();
        chk(0, "midrst_rd_en",    h[0].bus.fifo_rd_en, 0);
        chk(0, "midrst_rd_valid", h[0].bus.rd_valid,   0);
        chk(0, "midrst_err_flag", h[0].bus.err_flag,   0);
        repeat (2) nstep();
        rst_v[0] = 1'b0;
        repeat (5) nstep();
        s1 = get_st(0);
        chk(0, "midrst_no_valid", s1.n_valid - s0.n_valid, 0);
        s0 = s1;
        fill(0, 0, -1);
        wait_done(0, s0.n_done + 1);
        s1 = get_st(0);
        chk(0, "after_rst_n_valid", s1.n_valid - s0.n_valid, 512);
        chk(0, "after_rst_sum",     s1.sum - s0.sum,         130816);
        chk(0, "after_rst_err_cnt", h[0].bus.err_cnt,        0);

        // 8-bit wrap: two 256-word bursts, both starting at 0.
        s0 = get_st(1);
        fill(1, 0, -1);
        wait_done(1, s0.n_done + 1);
        fill(1, 0, -1);
        wait_done(1, s0.n_done + 2);
        s1 = get_st(1);
        chk(1, "wrap_n_valid", s1.n_valid - s0.n_valid, 512);
        chk(1, "wrap_sum",     s1.sum - s0.sum,         65280);
        chk(1, "wrap_n_done",  s1.n_done - s0.n_done,   2);
        chk(1, "wrap_err_cnt", h[1].bus.err_cnt,        0);

        // Read latency 2: same drain, one extra cycle to the first strobe.
        s0 = get_st(2);
        fill(2, 0, -1);
        wait_done(2, s0.n_done + 1);
        s1 = get_st(2);
        chk(2, "lat2_n_valid", s1.n_valid - s0.n_valid, 512);
        chk(2, "lat2_sum",     s1.sum - s0.sum,         130816);
        chk(2, "lat2_latency", s1.lat,                  3);
        chk(2, "lat2_n_done",  s1.n_done - s0.n_done,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
